param_sram_burst: RTL

- Parametrised single-port parameter SRAM; next generation of the fixed 4x32 parameter buffer.
- Adds per-byte write enables, configurable width and depth, and a burst-read engine with valid/ready backpressure.
- Adds a hardware clear sequence that zeroes the whole array.
- Sits between the weight/bias loader (write side) and the PE-array parameter feed (read side).

---
 rtl/param_sram_burst.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/param_sram_burst.sv
// Single-port parameter SRAM with byte-enable writes, a valid/ready burst-read
// engine and a hardware zero-fill sequence; IDLE arbitrates clear > read > write.
module param_sram_burst #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int LEN_W  = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   output logic                wr_ack,
   input  logic                rd_start,
   input  logic [ADDR_W-1:0]   rd_addr,
   input  logic [LEN_W-1:0]    rd_len,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic                rd_last,
   input  logic                clr_start,
   output logic                busy
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_CLEAR
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_issue;
   logic                w_clr_we;
   logic                w_wr_ack;
   logic                w_rd_accept;
   logic                w_clr_accept;

   logic [ADDR_W-1:0]   r_ptr;
   logic [LEN_W-1:0]    r_remaining;
   logic [ADDR_W-1:0]   r_clr_addr;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_rd_valid;
   logic                r_rd_last;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path infers a latch.
      w_state_nxt  = r_state;
      w_issue      = 1'b0;
      w_clr_we     = 1'b0;
      w_wr_ack     = 1'b0;
      w_rd_accept  = 1'b0;
      w_clr_accept = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (clr_start) begin
               w_state_nxt  = ST_CLEAR;
               w_clr_accept = 1'b1;
            end else if (rd_start) begin
               // A zero-length request still wins arbitration but starts nothing.
               if (rd_len != '0) begin
                  w_state_nxt = ST_READ;
                  w_rd_accept = 1'b1;
               end
            end else begin
               w_wr_ack = wr_en;
            end
         end
         ST_READ: begin
            w_issue = (r_remaining != '0) && (!r_rd_valid || rd_ready);
            if (w_issue && (r_remaining == LEN_W'(1))) w_state_nxt = ST_IDLE;
         end
         ST_CLEAR: begin
            w_clr_we = 1'b1;
            if (r_clr_addr == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_remaining <= '0;
         r_clr_addr  <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
      end else begin
         if (w_rd_accept) begin
            r_ptr       <= rd_addr;
            r_remaining <= rd_len;
         end else if (w_issue) begin
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
         end

         if (w_clr_accept)  r_clr_addr <= '0;
         else if (w_clr_we) r_clr_addr <= r_clr_addr + ADDR_W'(1);

         // The output register holds its beat until the consumer takes it.
         if (w_issue) begin
            r_rd_data  <= r_mem[r_ptr];
            r_rd_valid <= 1'b1;
            r_rd_last  <= (r_remaining == LEN_W'(1));
         end else if (rd_ready) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
         end
      end
   end

   // NOTE: the array has no reset; contents survive rst_n and only CLEAR zeroes them.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_clr_addr] <= '0;
      end else if (w_wr_ack) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   assign wr_ack   = w_wr_ack;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign rd_last  = r_rd_last;
   assign busy     = (r_state != ST_IDLE) || r_rd_valid;

endmodule
